// File: rtl/dsp_reset_responder.sv
// Card-side Sound Blaster DSP reset/identify responder.
// Watches ISA I/O cycles at one base address. A reset pulse written to base+6
// holds the DSP in reset. Releasing it starts a fixed delay, after which
// data-available is raised and base+A returns the acknowledge byte.
//
// Ports:
//   sys_clock  system clock; all logic runs on its rising edge
//   reset      asynchronous active-high reset
//   address    ISA address; only bits [9:0] are decoded
//   data_in    ISA write data
//   iow_n      ISA I/O write strobe, active low, asynchronous to sys_clock
//   ior_n      ISA I/O read strobe, active low, asynchronous to sys_clock
//   data_out   read data driven to the bus transceiver
//   data_dir   1 while the card drives the data bus
//   dsp_reset  1 while the DSP core is held in reset
//   read_ack   one-cycle pulse when the acknowledge-byte read completes
module dsp_reset_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0220,
  parameter logic [15:0] RESET_DELAY = 16'd8,
  parameter logic [7:0]  ACK_BYTE    = 8'hAA
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_in,
  input  logic        iow_n,
  input  logic        ior_n,
  output logic [7:0]  data_out,
  output logic        data_dir,
  output logic        dsp_reset,
  output logic        read_ack
);

  typedef enum logic [1:0] {
    IDLE,
    RESET_HELD,
    DELAY,
    ACK_PENDING
  } state_t;

  state_t state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        avail, avail_next;
  logic        read_ack_next;

  // Two-flop synchronisers plus one history flop for edge detection.
  logic iow_meta, iow_sync, iow_prev;
  logic ior_meta, ior_sync, ior_prev;

  // Set when the current read returned ACK_BYTE; its end event completes
  // the handshake.
  logic rd_is_ack;

  logic wr_start, rd_start, rd_end;
  logic hit_6, hit_a, hit_c, hit_e;
  logic rd_hit;
  logic [7:0] rd_data;

  localparam logic [9:0] BASE10 = BASE_ADDR[9:0];

  // Start events are dropped whenever both strobes are low together.
  assign wr_start = iow_prev && !iow_sync && ior_sync;
  assign rd_start = ior_prev && !ior_sync && iow_sync;
  assign rd_end   = !ior_prev && ior_sync;

  assign hit_6 = (address[9:0] == BASE10 + 10'h6);
  assign hit_a = (address[9:0] == BASE10 + 10'hA);
  assign hit_c = (address[9:0] == BASE10 + 10'hC);
  assign hit_e = (address[9:0] == BASE10 + 10'hE);

  // Read data snapshot taken at the read start event.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (hit_a) begin
      rd_hit  = 1'b1;
      rd_data = (state == ACK_PENDING) ? ACK_BYTE : 8'h00;
    end else if (hit_c) begin
      rd_hit  = 1'b1;
      rd_data = (state == RESET_HELD || state == DELAY) ? 8'h80 : 8'h00;
    end else if (hit_e) begin
      rd_hit  = 1'b1;
      rd_data = {avail, 7'b0};
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    avail_next    = avail;
    read_ack_next = 1'b0;

    case (state)
      DELAY: begin
        if (cnt == RESET_DELAY - 16'd1) begin
          state_next = ACK_PENDING;
          avail_next = 1'b1;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      ACK_PENDING: begin
        if (rd_end && rd_is_ack) begin
          state_next    = IDLE;
          avail_next    = 1'b0;
          read_ack_next = 1'b1;
        end
      end
      default: ;
    endcase

    // Reset-port writes override the sequencing above.
    if (wr_start && hit_6) begin
      if (data_in[0]) begin
        state_next    = RESET_HELD;
        cnt_next      = '0;
        avail_next    = 1'b0;
        read_ack_next = 1'b0;
      end else if (state == RESET_HELD) begin
        state_next = DELAY;
        cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      iow_meta  <= 1'b1;
      iow_sync  <= 1'b1;
      iow_prev  <= 1'b1;
      ior_meta  <= 1'b1;
      ior_sync  <= 1'b1;
      ior_prev  <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      avail     <= 1'b0;
      read_ack  <= 1'b0;
      dsp_reset <= 1'b0;
      data_out  <= '0;
      data_dir  <= 1'b0;
      rd_is_ack <= 1'b0;
    end else begin
      iow_meta  <= iow_n;
      iow_sync  <= iow_meta;
      iow_prev  <= iow_sync;
      ior_meta  <= ior_n;
      ior_sync  <= ior_meta;
      ior_prev  <= ior_sync;
      state     <= state_next;
      cnt       <= cnt_next;
      avail     <= avail_next;
      read_ack  <= read_ack_next;
      dsp_reset <= (state == RESET_HELD) || (state == DELAY);

      if (rd_start) begin
        if (rd_hit) begin
          data_out <= rd_data;
          data_dir <= 1'b1;
        end
        rd_is_ack <= hit_a && (state == ACK_PENDING);
      end else if (rd_end) begin
        data_out  <= '0;
        data_dir  <= 1'b0;
        rd_is_ack <= 1'b0;
      end

      // A new reset pulse cancels any handshake the current read was part of.
      if (wr_start && hit_6 && data_in[0]) begin
        rd_is_ack <= 1'b0;
      end
    end
  end

endmodule
